axi_slave_mem_responder: RTL and testbench



---
 rtl/axi_slave_mem_responder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_slave_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_responder.sv
// rtl/axi_slave_mem_responder.sv - AXI3 slave terminating write/read bursts in a local SRAM model
// Optional AXI_SLAVE_MEM_READY_DELAY_EN holds awready/arready low for READY_DELAY idle cycles.
module axi_slave_mem_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64,
   parameter int ID_WIDTH    = 4,
   parameter int MEM_DEPTH   = 256,
   parameter int READY_DELAY = 2
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [3:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [1:0]              awlock,
   input  logic [2:0]              awprot,
   input  logic [3:0]              awcache,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic [ID_WIDTH-1:0]     wid,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic [ID_WIDTH-1:0]     bid,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [3:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [1:0]              arlock,
   input  logic [2:0]              arprot,
   input  logic [3:0]              arcache,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic [ID_WIDTH-1:0]     rid,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);
   localparam int DATA_BYTES = DATA_WIDTH / 8;
   localparam int ADDR_SHIFT = $clog2(DATA_BYTES);
   localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * DATA_BYTES);
   localparam logic [2:0] MAX_SIZE = 3'(ADDR_SHIFT);
   localparam logic [3:0] DLY_LOAD = 4'(READY_DELAY);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   function automatic logic illegal_xfer(input logic [3:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
      logic bad_wrap;
      bad_wrap = (burst == 2'b10) &&
                 !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
      return (size > MAX_SIZE) || (burst == 2'b11) || bad_wrap;
   endfunction

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < MEM_BYTES;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[ADDR_SHIFT +: IDX_W];
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [3:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] bytes;
      logic [ADDR_WIDTH-1:0] cont;
      bytes = ADDR_WIDTH'(1) << size;
      cont  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
      case (burst)
         2'b01:   return (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
         2'b10:   return (a & ~(cont - ADDR_WIDTH'(1))) | ((a + bytes) & (cont - ADDR_WIDTH'(1)));
         default: return a;
      endcase
   endfunction

   // ---------------- write path ----------------
   w_state_t              w_state;
   logic [ID_WIDTH-1:0]   w_id;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [3:0]            w_len, w_beat;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;
   logic                  w_err, w_illegal;
   logic                  w_fire, w_last, w_beat_ok, w_beat_err;
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
   logic [3:0]            aw_dly;
   logic [3:0]            ar_dly;
`endif

   assign w_fire     = wvalid && wready;
   assign w_last     = (w_beat == w_len);
   assign w_beat_ok  = !w_illegal && in_range(w_addr);
   assign w_beat_err = !w_beat_ok || (wlast != w_last) || (wid != w_id);

   always_ff @(posedge aclk) begin
      if (w_fire && w_beat_ok) begin
         for (int i = 0; i < DATA_BYTES; i++)
            if (wstrb[i]) mem[word_idx(w_addr)][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state   <= W_IDLE;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bresp     <= 2'b00;
         bid       <= '0;
         w_id      <= '0;
         w_addr    <= '0;
         w_len     <= '0;
         w_beat    <= '0;
         w_size    <= '0;
         w_burst   <= '0;
         w_err     <= 1'b0;
         w_illegal <= 1'b0;
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
         aw_dly    <= DLY_LOAD;
`endif
      end else begin
         case (w_state)
            W_IDLE: begin
               if (awvalid && awready) begin
                  awready   <= 1'b0;
                  wready    <= 1'b1;
                  w_id      <= awid;
                  w_addr    <= awaddr;
                  w_len     <= awlen;
                  w_size    <= awsize;
                  w_burst   <= awburst;
                  w_illegal <= illegal_xfer(awlen, awsize, awburst);
                  w_beat    <= '0;
                  w_err     <= 1'b0;
                  w_state   <= W_DATA;
               end else begin
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
                  if (aw_dly != 4'd0) aw_dly <= aw_dly - 4'd1;
                  awready <= (aw_dly == 4'd0);
`else
                  awready <= 1'b1;
`endif
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                  w_beat <= w_beat + 4'd1;
                  w_err  <= w_err || w_beat_err;
                  if (w_last) begin
                     wready  <= 1'b0;
                     bvalid  <= 1'b1;
                     bid     <= w_id;
                     bresp   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  w_state <= W_IDLE;
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
                  aw_dly  <= DLY_LOAD;
`endif
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // ---------------- read path ----------------
   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] r_addr, r_next;
   logic [3:0]            r_len, r_beat;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_illegal, ar_illegal, ar_ok, rn_ok;

   assign ar_illegal = illegal_xfer(arlen, arsize, arburst);
   assign ar_ok      = !ar_illegal && in_range(araddr);
   assign r_next     = next_addr(r_addr, r_len, r_size, r_burst);
   assign rn_ok      = !r_illegal && in_range(r_next);

   // rdata is loaded one beat ahead so each handshake is followed by the next beat without a bubble
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= R_IDLE;
         arready   <= 1'b0;
         rvalid    <= 1'b0;
         rlast     <= 1'b0;
         rdata     <= '0;
         rresp     <= 2'b00;
         rid       <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_illegal <= 1'b0;
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
         ar_dly    <= DLY_LOAD;
`endif
      end else begin
         case (r_state)
            R_IDLE: begin
               if (arvalid && arready) begin
                  arready   <= 1'b0;
                  rid       <= arid;
                  r_addr    <= araddr;
                  r_len     <= arlen;
                  r_size    <= arsize;
                  r_burst   <= arburst;
                  r_illegal <= ar_illegal;
                  r_beat    <= '0;
                  rvalid    <= 1'b1;
                  rlast     <= (arlen == 4'd0);
                  rdata     <= ar_ok ? mem[word_idx(araddr)] : '0;
                  rresp     <= ar_ok ? 2'b00 : 2'b10;
                  r_state   <= R_DATA;
               end else begin
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
                  if (ar_dly != 4'd0) ar_dly <= ar_dly - 4'd1;
                  arready <= (ar_dly == 4'd0);
`else
                  arready <= 1'b1;
`endif
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     r_state <= R_IDLE;
`ifdef AXI_SLAVE_MEM_READY_DELAY_EN
                     ar_dly  <= DLY_LOAD;
`endif
                  end else begin
                     r_addr <= r_next;
                     r_beat <= r_beat + 4'd1;
                     rlast  <= ((r_beat + 4'd1) == r_len);
                     rdata  <= rn_ok ? mem[word_idx(r_next)] : '0;
                     rresp  <= rn_ok ? 2'b00 : 2'b10;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ^{awlock, awprot, awcache, arlock, arprot, arcache, DLY_LOAD};

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// tb/tb_axi_slave_mem_responder.sv - self-checking bench for axi_slave_mem_responder
module tb_axi_slave_mem_responder;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] awaddr, araddr;
   logic [3:0]  awlen, arlen, awid, arid, wid, awcache, arcache;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst, awlock, arlock;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [63:0] wdata, rdata;
   logic [7:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [3:0]  bid, rid;

   axi_slave_mem_responder dut (
      .aclk(aclk), .aresetn(aresetn),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
      .awlock(awlock), .awprot(awprot), .awcache(awcache), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
      .arlock(arlock), .arprot(arprot), .arcache(arcache), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  model [0:2047];
   logic [63:0] wbuf [16];
   logic [7:0]  sbuf [16];
   logic [63:0] rbuf [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic bit legal(input int len, input int size, input int burst);
      return (size <= 3) && (burst != 3) && (burst != 2 || len inside {1, 3, 7, 15});
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
      longint s, bytes, cont, base;
      s = start;
      bytes = longint'(1) << size;
      if (burst == 0) return start;
      if (burst == 1) return (i == 0) ? start : 32'((s / bytes) * bytes + i * bytes);
      cont = (len + 1) * bytes;
      base = (s / cont) * cont;
      return 32'(base + ((s - base) + i * bytes) % cont);
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input bit bad_wlast,
                           input bit bad_wid, output logic [1:0] resp);
      int guard;
      logic [31:0] a;
      bit err, ok, wl;
      err = 0;
      awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
      awvalid = 1'b1;
      guard = 0;
      while (!awready && guard < 50) begin @(negedge aclk); guard++; end
      check("aw_ready", awready, 1'b1);
      @(negedge aclk);
      awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         a  = beat_addr(addr, len, size, burst, i);
         wl = bad_wlast ? (i == 0) : (i == len);
         ok = legal(len, size, burst) && a < 2048;
         wdata = wbuf[i]; wstrb = sbuf[i]; wlast = wl;
         wid = bad_wid ? (id ^ 4'h1) : id;
         wvalid = 1'b1;
         if (!ok || wl != (i == len) || bad_wid) err = 1;
         if (ok)
            for (int j = 0; j < 8; j++)
               if (sbuf[i][j]) model[(a / 8) * 8 + j] = wbuf[i][j*8 +: 8];
         guard = 0;
         while (!wready && guard < 50) begin @(negedge aclk); guard++; end
         check("w_ready", wready, 1'b1);
         @(negedge aclk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      bready = 1'b1;
      guard = 0;
      while (!bvalid && guard < 50) begin @(negedge aclk); guard++; end
      check("b_valid", bvalid, 1'b1);
      resp = bresp;
      check("bid", bid, id);
      check("bresp_model", bresp, err ? 2'b10 : 2'b00);
      @(negedge aclk);
      bready = 1'b0;
      check("b_done", bvalid, 1'b0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int stall_beat,
                          input int stall_cyc, input bit rnd, output logic [1:0] first_resp);
      int guard, beat, sb;
      logic [31:0] a;
      logic [63:0] ed;
      logic [1:0]  er;
      sb = stall_beat;
      first_resp = 2'b11;
      arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
      arvalid = 1'b1;
      guard = 0;
      while (!arready && guard < 50) begin @(negedge aclk); guard++; end
      check("ar_ready", arready, 1'b1);
      @(negedge aclk);
      arvalid = 1'b0;
      beat = 0; guard = 0;
      while (beat <= len && guard < 300) begin
         a = beat_addr(addr, len, size, burst, beat);
         ed = '0; er = 2'b10;
         if (legal(len, size, burst) && a < 2048) begin
            er = 2'b00;
            for (int j = 0; j < 8; j++) ed[j*8 +: 8] = model[(a / 8) * 8 + j];
         end
         if (beat == sb && rvalid) begin
            rready = 1'b0;
            for (int k = 0; k < stall_cyc; k++) begin
               @(negedge aclk);
               check("stall_valid", rvalid, 1'b1);
               check("stall_data", rdata, ed);
               check("stall_last", rlast, beat == len);
            end
            sb = -1;
         end
         rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rvalid && rready) begin
            check("rdata", rdata, ed);
            check("rresp", rresp, er);
            check("rlast", rlast, beat == len);
            check("rid", rid, id);
            rbuf[beat] = rdata;
            if (beat == 0) first_resp = rresp;
            beat++;
         end
         @(negedge aclk);
         guard++;
      end
      rready = 1'b0;
      check("r_beats", beat, len + 1);
      check("r_done", rvalid, 1'b0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      int          len;
      int          size;
      int          burst;
      bit          bad_wlast;
      bit          bad_wid;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [1:0] resp;
      int guard, burst, size, len, addr;
      vecs[0]  = '{1'b1, 32'h100, 3, 3, 1, 1'b0, 1'b0, 2'b00};
      vecs[1]  = '{1'b1, 32'h140, 1, 3, 1, 1'b1, 1'b0, 2'b10};
      vecs[2]  = '{1'b1, 32'h180, 0, 3, 1, 1'b0, 1'b1, 2'b10};
      vecs[3]  = '{1'b1, 32'h1C0, 1, 3, 3, 1'b0, 1'b0, 2'b10};
      vecs[4]  = '{1'b1, 32'h200, 2, 3, 2, 1'b0, 1'b0, 2'b10};
      vecs[5]  = '{1'b1, 32'h7F8, 1, 3, 1, 1'b0, 1'b0, 2'b10};
      vecs[6]  = '{1'b1, 32'h300, 3, 2, 0, 1'b0, 1'b0, 2'b00};
      vecs[7]  = '{1'b1, 32'h031, 7, 0, 2, 1'b0, 1'b0, 2'b00};
      vecs[8]  = '{1'b0, 32'h800, 3, 3, 1, 1'b0, 1'b0, 2'b10};
      vecs[9]  = '{1'b0, 32'h018, 3, 3, 2, 1'b0, 1'b0, 2'b00};
      vecs[10] = '{1'b0, 32'h100, 3, 4, 1, 1'b0, 1'b0, 2'b10};
      vecs[11] = '{1'b0, 32'h7F0, 3, 3, 1, 1'b0, 1'b0, 2'b00};
      vecs[12] = '{1'b0, 32'h000, 0, 3, 0, 1'b0, 1'b0, 2'b00};
      vecs[13] = '{1'b0, 32'h040, 1, 3, 3, 1'b0, 1'b0, 2'b10};

      aresetn = 1'b0;
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awid = '0; awlock = '0;
      awprot = '0; awcache = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wid = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0; arid = '0; arlock = '0;
      arprot = '0; arcache = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (2) @(negedge aclk);
      check("rst_awready", awready, 1'b0);
      check("rst_arready", arready, 1'b0);
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rdata", rdata, 64'h0);
      check("rst_rlast", rlast, 1'b0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("post_rst_awready", awready, 1'b1);
      check("post_rst_arready", arready, 1'b1);

      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) begin
            wbuf[i] = {$urandom, $urandom};
            sbuf[i] = 8'hFF;
         end
         do_write(4'(b), 32'(b * 128), 15, 3, 1, 1'b0, 1'b0, resp);
         check("init_bresp", resp, 2'b00);
      end

      for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hA0 + i; sbuf[i] = 8'hFF; end
      do_write(4'h5, 32'h10, 3, 3, 1, 1'b0, 1'b0, resp);
      check("incr_bresp", resp, 2'b00);
      do_read(4'h6, 32'h10, 3, 3, 1, -1, 0, 1'b0, resp);
      for (int i = 0; i < 4; i++) check("incr_rdata", rbuf[i], 64'hA0 + i);

      for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hB0 + i; sbuf[i] = 8'hFF; end
      do_write(4'h7, 32'h00, 3, 3, 1, 1'b0, 1'b0, resp);
      do_read(4'h8, 32'h18, 3, 3, 2, -1, 0, 1'b0, resp);
      check("wrap_rresp", resp, 2'b00);
      for (int i = 0; i < 4; i++) check("wrap_rdata", rbuf[i], 64'hB0 + ((i + 3) % 4));

      wbuf[0] = 64'h1111_1111_1111_1111; sbuf[0] = 8'hFF;
      do_write(4'h1, 32'h20, 0, 3, 1, 1'b0, 1'b0, resp);
      wbuf[0] = 64'h5A00; sbuf[0] = 8'h02;
      do_write(4'h2, 32'h21, 0, 0, 1, 1'b0, 1'b0, resp);
      check("narrow_bresp", resp, 2'b00);
      do_read(4'h3, 32'h20, 0, 3, 1, -1, 0, 1'b0, resp);
      check("narrow_rdata", rbuf[0], 64'h1111_1111_1111_5A11);

      do_read(4'h9, 32'h40, 3, 3, 1, 1, 5, 1'b0, resp);

      for (int v = 0; v < 14; v++) begin
         if (vecs[v].wr) begin
            for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom); end
            do_write(4'(v), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                     vecs[v].bad_wlast, vecs[v].bad_wid, resp);
         end else begin
            do_read(4'(v), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, -1, 0, 1'b0, resp);
         end
         check("vec_resp", resp, vecs[v].exp_resp);
      end

      for (int t = 0; t < 60; t++) begin
         burst = $urandom_range(0, 2);
         size  = $urandom_range(0, 3);
         len   = (burst == 2) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
         addr  = $urandom_range(0, 2200);
         if (burst == 2) addr = addr & ~((1 << size) - 1);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom); end
            do_write(4'($urandom), 32'(addr), len, size, burst, 1'b0, 1'b0, resp);
         end else begin
            do_read(4'($urandom), 32'(addr), len, size, burst, -1, 0, 1'b1, resp);
         end
      end

      awid = 4'h3; awaddr = 32'h80; awlen = 4'd3; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
      guard = 0;
      while (!awready && guard < 50) begin @(negedge aclk); guard++; end
      @(negedge aclk);
      awvalid = 1'b0;
      wdata = '0; wstrb = 8'h00; wlast = 1'b0; wid = 4'h3; wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 50) begin @(negedge aclk); guard++; end
      @(negedge aclk);
      wvalid = 1'b0;
      aresetn = 1'b0;
      #1;
      check("midrst_awready", awready, 1'b0);
      check("midrst_bvalid", bvalid, 1'b0);
      check("midrst_wready", wready, 1'b0);
      @(negedge aclk);
      check("midrst_awready_hold", awready, 1'b0);
      check("midrst_bvalid_hold", bvalid, 1'b0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rel_awready", awready, 1'b1);
      check("rel_wready", wready, 1'b0);
      bready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("rel_no_b", bvalid, 1'b0);
         @(negedge aclk);
      end
      bready = 1'b0;
      do_read(4'hA, 32'h80, 3, 3, 1, -1, 0, 1'b0, resp);
      check("rel_read_resp", resp, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
